// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor.
// Two WIDTH-bit operands are captured on an accepted start and folded through
// a single full-adder cell, LSB first, one bit per clock. The carry between
// bits lives in c_q. Subtraction is A + ~B + 1: B is inverted at capture and
// the carry register is preset to 1.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | waiting for start; sum/carry hold the last completed result
// S_RUN  | one operand bit processed per edge, bit counter in cnt_q
// S_DONE | result just presented (done=1); start here re-launches at once
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] r_q;
   logic             c_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             busy_q;
   logic             done_q;

   logic             s_d;
   logic             c_d;
   logic [WIDTH-1:0] s_msb;
   logic [WIDTH-1:0] r_d;

   // Full-adder cell on the current LSBs, plus the result register's next
   // value with the new sum bit entering at the MSB. The MSB is placed via a
   // mask rather than a part-select so that WIDTH=1 elaborates cleanly.
   always_comb begin
      s_d            = a_q[0] ^ b_q[0] ^ c_q;
      c_d            = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
      s_msb          = '0;
      s_msb[WIDTH-1] = s_d;
      r_d            = (r_q >> 1) | s_msb;
   end

   // Sequencer: operand capture, per-bit datapath update and result hand-off.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= A;
                  b_q     <= sub ? ~B : B;
                  c_q     <= sub ? 1'b1 : cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               c_q   <= c_d;
               r_q   <= r_d;
               cnt_q <= cnt_q + CW'(1);
               // The edge that consumes the MSB also publishes the result.
               if (cnt_q == LAST_BIT) begin
                  sum_q   <= r_d;
                  carry_q <= c_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign carry = carry_q;

endmodule
